snake_map_ram: RTL and testbench

Board-map memory serving the 16x16 game grid: 256 cells, each holding a 4-bit cell code. It is the responder for the map-access protocol that the food generator and snake engine drive (address, read enable, write enable, write data), and returns registered read data. It arbitrates the two requesters and clears the board to empty after reset. It also maintains a running count of empty cells so the food generator can detect a full board.

---
 rtl/snake_map_ram.sv | 123 ++++++++++++
 tb/tb_snake_map_ram.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/snake_map_ram.sv
// Board-map memory for the 16x16 snake grid: two-port arbitrated access,
// power-up clear sweep and a running count of empty cells.
module snake_map_ram #(
    parameter int                ADDR_W     = 8,
    parameter int                DATA_W     = 4,
    parameter logic [DATA_W-1:0] EMPTY_CODE = 4'hF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              snake_read_EN,
    input  logic              snake_write_EN,
    input  logic [ADDR_W-1:0] snake_addr,
    input  logic [DATA_W-1:0] snake_wdata,
    output logic [DATA_W-1:0] snake_data,
    output logic              snake_ack,
    input  logic              food_read_EN,
    input  logic              food_write_EN,
    input  logic [ADDR_W-1:0] food_addr,
    input  logic [DATA_W-1:0] food_wdata,
    output logic [DATA_W-1:0] food_data,
    output logic              food_ack,
    output logic              ready,
    output logic [ADDR_W:0]   empty_count
);

    localparam int                DEPTH      = 1 << ADDR_W;
    localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_CELL  = ADDR_W'(DEPTH - 1);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t            state;
    logic [ADDR_W-1:0] clear_ptr;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              a_req;
    logic              b_req;
    logic              serve_a;
    logic              serve_b;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] old_cell;

    // Port A has fixed priority; the sweep owns the write port while clearing.
    always_comb begin
        a_req   = snake_read_EN | snake_write_EN;
        b_req   = food_read_EN | food_write_EN;
        serve_a = (state == RUN) && a_req;
        serve_b = (state == RUN) && !a_req && b_req;
        wr_en   = 1'b0;
        wr_addr = clear_ptr;
        wr_data = EMPTY_CODE;
        if (state == CLEAR) begin
            wr_en = rst_n;
        end else if (serve_a) begin
            wr_en   = snake_write_EN;
            wr_addr = snake_addr;
            wr_data = snake_wdata;
        end else if (serve_b) begin
            wr_en   = food_write_EN;
            wr_addr = food_addr;
            wr_data = food_wdata;
        end
    end

    assign old_cell = mem[wr_addr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read data is taken from the array before this edge's write lands,
    // which gives read-before-write when a port reads and writes together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= CLEAR;
            clear_ptr   <= '0;
            ready       <= 1'b0;
            snake_ack   <= 1'b0;
            food_ack    <= 1'b0;
            snake_data  <= '0;
            food_data   <= '0;
            empty_count <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    snake_ack <= 1'b0;
                    food_ack  <= 1'b0;
                    clear_ptr <= clear_ptr + ADDR_W'(1);
                    if (clear_ptr == LAST_CELL) begin
                        state       <= RUN;
                        ready       <= 1'b1;
                        empty_count <= FULL_COUNT;
                    end
                end
                RUN: begin
                    snake_ack <= serve_a;
                    food_ack  <= serve_b;
                    if (serve_a && snake_read_EN) begin
                        snake_data <= mem[snake_addr];
                    end
                    if (serve_b && food_read_EN) begin
                        food_data <= mem[food_addr];
                    end
                    if (wr_en) begin
                        if (old_cell == EMPTY_CODE && wr_data != EMPTY_CODE
                            && empty_count != '0) begin
                            empty_count <= empty_count - (ADDR_W + 1)'(1);
                        end else if (old_cell != EMPTY_CODE && wr_data == EMPTY_CODE
                                     && empty_count != FULL_COUNT) begin
                            empty_count <= empty_count + (ADDR_W + 1)'(1);
                        end
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end

endmodule

// File: tb/tb_snake_map_ram.sv
// Self-checking bench for snake_map_ram: directed protocol steps followed by
// randomized two-port traffic, all checked against an array model of the board.
module tb_snake_map_ram;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       snake_read_EN = 1'b0;
    logic       snake_write_EN = 1'b0;
    logic [7:0] snake_addr = '0;
    logic [3:0] snake_wdata = '0;
    logic [3:0] snake_data;
    logic       snake_ack;
    logic       food_read_EN = 1'b0;
    logic       food_write_EN = 1'b0;
    logic [7:0] food_addr = '0;
    logic [3:0] food_wdata = '0;
    logic [3:0] food_data;
    logic       food_ack;
    logic       ready;
    logic [8:0] empty_count;

    int         n_cmp = 0;
    int         n_fail = 0;
    logic [3:0] board [256];
    logic [3:0] exp_sd;
    logic [3:0] exp_fd;

    snake_map_ram dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .snake_read_EN  (snake_read_EN),
        .snake_write_EN (snake_write_EN),
        .snake_addr     (snake_addr),
        .snake_wdata    (snake_wdata),
        .snake_data     (snake_data),
        .snake_ack      (snake_ack),
        .food_read_EN   (food_read_EN),
        .food_write_EN  (food_write_EN),
        .food_addr      (food_addr),
        .food_wdata     (food_wdata),
        .food_data      (food_data),
        .food_ack       (food_ack),
        .ready          (ready),
        .empty_count    (empty_count)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int count_empty();
        int n = 0;
        for (int i = 0; i < 256; i++) if (board[i] == 4'hF) n++;
        return n;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One bus cycle: drive both ports, then check the response against the board model.
    task automatic apply_stimulus(input string tag,
                                  input logic a_rd, input logic a_wr,
                                  input logic [7:0] a_addr, input logic [3:0] a_wd,
                                  input logic b_rd, input logic b_wr,
                                  input logic [7:0] b_addr, input logic [3:0] b_wd,
                                  output logic b_served);
        logic a_go;
        logic b_go;
        snake_read_EN  = a_rd;
        snake_write_EN = a_wr;
        snake_addr     = a_addr;
        snake_wdata    = a_wd;
        food_read_EN   = b_rd;
        food_write_EN  = b_wr;
        food_addr      = b_addr;
        food_wdata     = b_wd;
        tick();
        a_go = a_rd | a_wr;
        b_go = !a_go && (b_rd | b_wr);
        if (a_go) begin
            if (a_rd) exp_sd = board[a_addr];
            if (a_wr) board[a_addr] = a_wd;
        end else if (b_go) begin
            if (b_rd) exp_fd = board[b_addr];
            if (b_wr) board[b_addr] = b_wd;
        end
        b_served = b_go;
        check_output({tag, ".snake_ack"}, 9'(snake_ack), 9'(a_go));
        check_output({tag, ".food_ack"}, 9'(food_ack), 9'(b_go));
        check_output({tag, ".snake_data"}, 9'(snake_data), 9'(exp_sd));
        check_output({tag, ".food_data"}, 9'(food_data), 9'(exp_fd));
        check_output({tag, ".empty_count"}, empty_count, 9'(count_empty()));
        check_output({tag, ".ready"}, 9'(ready), 9'd1);
    endtask

    task automatic idle_inputs();
        snake_read_EN  = 1'b0;
        snake_write_EN = 1'b0;
        food_read_EN   = 1'b0;
        food_write_EN  = 1'b0;
    endtask

    // Hold reset for a few edges and verify the reset values of every output.
    task automatic hold_reset(input int cycles);
        rst_n = 1'b0;
        idle_inputs();
        repeat (cycles) tick();
        check_output("rst.ready", 9'(ready), 9'd0);
        check_output("rst.snake_ack", 9'(snake_ack), 9'd0);
        check_output("rst.food_ack", 9'(food_ack), 9'd0);
        check_output("rst.snake_data", 9'(snake_data), 9'd0);
        check_output("rst.food_data", 9'(food_data), 9'd0);
        check_output("rst.empty_count", empty_count, 9'd0);
        for (int i = 0; i < 256; i++) board[i] = 4'hF;
        exp_sd = '0;
        exp_fd = '0;
    endtask

    // Release reset and count edges until ready, with requests driven that must be ignored.
    task automatic wait_ready(input string tag);
        int edges = 0;
        rst_n          = 1'b1;
        snake_write_EN = 1'b1;
        snake_addr     = 8'h12;
        snake_wdata    = 4'h3;
        food_read_EN   = 1'b1;
        food_addr      = 8'h12;
        while (!ready && edges < 400) begin
            tick();
            edges++;
            if (snake_ack || food_ack) begin
                check_output({tag, ".ack_in_clear"}, 9'(snake_ack | food_ack), 9'd0);
            end
        end
        idle_inputs();
        check_output({tag, ".sweep_len"}, 9'(edges), 9'd256);
        check_output({tag, ".empty_count"}, empty_count, 9'd256);
    endtask

    initial begin
        logic b_served;
        logic b_pend;
        logic b_rd;
        logic b_wr;
        logic [7:0] b_addr;
        logic [3:0] b_wd;
        logic a_rd;
        logic a_wr;
        logic [3:0] wd;

        $display("[TB] start");
        hold_reset(3);
        wait_ready("sweep0");

        apply_stimulus("rd00", 1, 0, 8'h00, 4'h0, 0, 0, 8'h00, 4'h0, b_served);
        apply_stimulus("rd7f", 0, 0, 8'h00, 4'h0, 1, 0, 8'h7F, 4'h0, b_served);
        apply_stimulus("rdff", 1, 0, 8'hFF, 4'h0, 0, 0, 8'h00, 4'h0, b_served);

        apply_stimulus("wr12", 0, 1, 8'h12, 4'h3, 0, 0, 8'h00, 4'h0, b_served);
        apply_stimulus("brd12", 0, 0, 8'h00, 4'h0, 1, 0, 8'h12, 4'h0, b_served);
        apply_stimulus("idle", 0, 0, 8'h00, 4'h0, 0, 0, 8'h00, 4'h0, b_served);

        apply_stimulus("both1", 1, 0, 8'h12, 4'h0, 1, 0, 8'h34, 4'h0, b_served);
        check_output("both1.stalled", 9'(b_served), 9'd0);
        apply_stimulus("both2", 0, 0, 8'h00, 4'h0, 1, 0, 8'h34, 4'h0, b_served);

        apply_stimulus("brw34", 0, 0, 8'h00, 4'h0, 1, 1, 8'h34, 4'hE, b_served);
        check_output("brw34.old", 9'(food_data), 9'hF);
        apply_stimulus("brd34", 0, 0, 8'h00, 4'h0, 1, 0, 8'h34, 4'h0, b_served);
        check_output("brd34.new", 9'(food_data), 9'hE);

        apply_stimulus("fOverF", 0, 1, 8'h50, 4'hF, 0, 0, 8'h00, 4'h0, b_served);
        apply_stimulus("fOver3", 0, 1, 8'h12, 4'hF, 0, 0, 8'h00, 4'h0, b_served);
        apply_stimulus("3OverE", 0, 0, 8'h00, 4'h0, 0, 1, 8'h34, 4'h3, b_served);

        apply_stimulus("samewr1", 0, 1, 8'h40, 4'h1, 0, 1, 8'h40, 4'h2, b_served);
        apply_stimulus("samewr2", 0, 0, 8'h00, 4'h0, 0, 1, 8'h40, 4'h2, b_served);
        apply_stimulus("samewr3", 1, 0, 8'h40, 4'h0, 0, 0, 8'h00, 4'h0, b_served);

        // Random traffic; port B holds its request until it is served.
        b_pend = 1'b0;
        b_rd   = 1'b0;
        b_wr   = 1'b0;
        b_addr = '0;
        b_wd   = '0;
        for (int i = 0; i < 300; i++) begin
            a_rd = 1'b0;
            a_wr = 1'b0;
            if ($urandom_range(0, 1) == 1) begin
                a_rd = 1'($urandom);
                a_wr = 1'($urandom);
                if (!a_rd && !a_wr) a_rd = 1'b1;
            end
            if (!b_pend && $urandom_range(0, 9) < 6) begin
                b_rd   = 1'($urandom);
                b_wr   = 1'($urandom);
                if (!b_rd && !b_wr) b_wr = 1'b1;
                b_addr = 8'($urandom_range(0, 31));
                b_wd   = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom);
                b_pend = 1'b1;
            end
            wd = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom);
            apply_stimulus("rand", a_rd, a_wr, 8'($urandom_range(0, 31)), wd,
                           b_pend & b_rd, b_pend & b_wr, b_addr, b_wd, b_served);
            if (b_served) b_pend = 1'b0;
        end

        apply_stimulus("pre_rst", 0, 1, 8'h12, 4'h3, 0, 0, 8'h00, 4'h0, b_served);
        hold_reset(2);
        rst_n = 1'b1;
        repeat (100) tick();
        check_output("mid.ready", 9'(ready), 9'd0);
        hold_reset(1);
        wait_ready("sweep1");
        apply_stimulus("post12", 0, 0, 8'h00, 4'h0, 1, 0, 8'h12, 4'h0, b_served);
        check_output("post12.val", 9'(food_data), 9'hF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
